// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 raster timing with sync, blank, frame pulses and tile fields
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        vga_clk,
    input  logic        reset,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        hs,
    output logic        vs,
    output logic        blank,
    output logic        frame_start,
    output logic        vblank_start,
    output logic [15:0] frame_count,
    output logic [4:0]  tile_col,
    output logic [4:0]  tile_row,
    output logic [4:0]  tile_px,
    output logic [4:0]  tile_py
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0]  r_hcnt;
    logic [9:0]  r_vcnt;
    logic        r_hs;
    logic        r_vs;
    logic        r_blank;
    logic        r_frame_start;
    logic        r_vblank_start;
    logic [15:0] r_frame_count;

    logic        w_h_wrap;
    logic [9:0]  w_hnext;
    logic [9:0]  w_vnext;
    logic        w_vblank_next;

    // Decode everything from the next position so every output lines up with DrawX/DrawY.
    assign w_h_wrap      = (r_hcnt == H_LAST);
    assign w_hnext       = w_h_wrap ? 10'd0 : r_hcnt + 10'd1;
    assign w_vnext       = w_h_wrap ? ((r_vcnt == V_LAST) ? 10'd0 : r_vcnt + 10'd1) : r_vcnt;
    assign w_vblank_next = (w_hnext == 10'd0) && (w_vnext == V_VIS);

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_hcnt         <= H_LAST;
            r_vcnt         <= V_LAST;
            r_hs           <= 1'b1;
            r_vs           <= 1'b1;
            r_blank        <= 1'b0;
            r_frame_start  <= 1'b0;
            r_vblank_start <= 1'b0;
            r_frame_count  <= 16'd0;
        end else begin
            r_hcnt         <= w_hnext;
            r_vcnt         <= w_vnext;
            r_hs           <= !((w_hnext >= HS_START) && (w_hnext < HS_END));
            r_vs           <= !((w_vnext >= VS_START) && (w_vnext < VS_END));
            r_blank        <= (w_hnext < H_VIS) && (w_vnext < V_VIS);
            r_frame_start  <= (w_hnext == 10'd0) && (w_vnext == 10'd0);
            r_vblank_start <= w_vblank_next;
            if (w_vblank_next) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    assign DrawX        = r_hcnt;
    assign DrawY        = r_vcnt;
    assign hs           = r_hs;
    assign vs           = r_vs;
    assign blank        = r_blank;
    assign frame_start  = r_frame_start;
    assign vblank_start = r_vblank_start;
    assign frame_count  = r_frame_count;
    assign tile_col     = r_hcnt[9:5];
    assign tile_px      = r_hcnt[4:0];
    assign tile_row     = r_vcnt[9:5];
    assign tile_py      = r_vcnt[4:0];

endmodule
